// File: rtl/mio_clkgen.sv
// MIO link clock-phase generator: divides clk into two phase-offset clock levels
// with edge strobes, using shadowed settings that are applied through a controlled restart.
module mio_clkgen #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            en,
    input  logic            clkchange,
    input  logic [DW-1:0]   clkdiv,
    input  logic [2*DW-1:0] clkphase0,
    input  logic [2*DW-1:0] clkphase1,
    output logic            clkout0,
    output logic            clkout1,
    output logic            rise0,
    output logic            fall0,
    output logic            rise1,
    output logic            fall1,
    output logic            clkstable
);

    typedef enum logic [1:0] {
        S_OFF,
        S_LOAD,
        S_SETTLE,
        S_RUN
    } state_t;

    localparam logic [DW-1:0] ONE = DW'(1);

    state_t            state;
    state_t            state_nxt;
    logic              settle_cnt;
    logic [DW-1:0]     cnt;
    logic [DW-1:0]     div_q;
    logic [2*DW-1:0]   ph0_q;
    logic [2*DW-1:0]   ph1_q;
    logic [DW-1:0]     div_eff;
    logic              run_stay;
    logic [2:0]        ev0;
    logic [2:0]        ev1;

    // Returns {next level, rise strobe, fall strobe}; rise wins when both phases match,
    // and a strobe only fires on a real level change.
    function automatic logic [2:0] edge_eval(
        input logic [DW-1:0]   c,
        input logic [2*DW-1:0] ph,
        input logic            lvl
    );
        logic [2:0] res;
        res = {lvl, 2'b00};
        if (c == ph[DW-1:0]) begin
            res = {1'b1, ~lvl, 1'b0};
        end else if (c == ph[2*DW-1:DW]) begin
            res = {1'b0, 1'b0, lvl};
        end
        return res;
    endfunction

    // NOTE: every combinational output gets a default before any branch, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = S_OFF;
        end else begin
            case (state)
                S_OFF:    state_nxt = S_LOAD;
                S_LOAD:   state_nxt = clkchange ? S_LOAD : S_SETTLE;
                S_SETTLE: begin
                    if (clkchange)       state_nxt = S_LOAD;
                    else if (settle_cnt) state_nxt = S_RUN;
                end
                S_RUN:    if (clkchange) state_nxt = S_LOAD;
                default:  state_nxt = S_OFF;
            endcase
        end
    end

    always_comb begin
        div_eff  = (div_q == '0) ? ONE : div_q;
        run_stay = (state == S_RUN) && (state_nxt == S_RUN);
        ev0      = edge_eval(cnt, ph0_q, clkout0);
        ev1      = edge_eval(cnt, ph1_q, clkout1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= S_OFF;
            settle_cnt <= 1'b0;
            clkstable  <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= (state == S_SETTLE) && (state_nxt == S_SETTLE);
            clkstable  <= (state_nxt == S_RUN);
        end
    end

    // Shadows only follow the register block during LOAD, so writes at any other
    // time cannot disturb a running waveform.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div_q <= '0;
            ph0_q <= '0;
            ph1_q <= '0;
        end else if (state == S_LOAD) begin
            div_q <= clkdiv;
            ph0_q <= clkphase0;
            ph1_q <= clkphase1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (run_stay) begin
            cnt <= (cnt >= div_eff) ? '0 : cnt + ONE;
        end else begin
            cnt <= '0;
        end
    end

    // Leaving RUN clears levels and strobes at once, truncating any high phase.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            clkout0 <= 1'b0;
            rise0   <= 1'b0;
            fall0   <= 1'b0;
            clkout1 <= 1'b0;
            rise1   <= 1'b0;
            fall1   <= 1'b0;
        end else if (run_stay) begin
            {clkout0, rise0, fall0} <= ev0;
            {clkout1, rise1, fall1} <= ev1;
        end else begin
            clkout0 <= 1'b0;
            rise0   <= 1'b0;
            fall0   <= 1'b0;
            clkout1 <= 1'b0;
            rise1   <= 1'b0;
            fall1   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mio_clkgen.sv
// Self-checking bench for mio_clkgen: directed table, corner sequences and a
// randomized run against a restart-timeline reference model.
module tb_mio_clkgen;

    localparam int DW = 8;

    logic            clk;
    logic            nreset;
    logic            en;
    logic            clkchange;
    logic [DW-1:0]   clkdiv;
    logic [2*DW-1:0] clkphase0;
    logic [2*DW-1:0] clkphase1;
    logic            clkout0;
    logic            clkout1;
    logic            rise0;
    logic            fall0;
    logic            rise1;
    logic            fall1;
    logic            clkstable;

    mio_clkgen #(.DW(DW)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .en        (en),
        .clkchange (clkchange),
        .clkdiv    (clkdiv),
        .clkphase0 (clkphase0),
        .clkphase1 (clkphase1),
        .clkout0   (clkout0),
        .clkout1   (clkout1),
        .rise0     (rise0),
        .fall0     (fall0),
        .rise1     (rise1),
        .fall1     (fall1),
        .clkstable (clkstable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Vector order: {clkstable, clkout0, clkout1, rise0, fall0, rise1, fall1}
    function automatic logic [6:0] dut_vec();
        return {clkstable, clkout0, clkout1, rise0, fall0, rise1, fall1};
    endfunction

    // Reference model: m_t counts edges since the LOAD edge; settings captured at
    // t 0->1, outputs valid from t>=3, and the k-th evaluation uses cnt = k mod period.
    bit m_active;
    int m_t;
    int m_div;
    int m_r[2];
    int m_f[2];
    bit m_lvl[2];
    bit m_rs[2];
    bit m_fs[2];

    task automatic model_reset();
        m_active = 0;
        m_t      = 0;
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 0; m_rs[i] = 0; m_fs[i] = 0;
        end
    endtask

    task automatic model_step(input bit e, input bit c);
        bit was_run;
        int p;
        int k;
        was_run = m_active && (m_t >= 3);
        for (int i = 0; i < 2; i++) begin
            m_rs[i] = 0; m_fs[i] = 0;
        end
        if (!e) begin
            m_active = 0; m_t = 0;
        end else if (!m_active || c) begin
            m_active = 1; m_t = 0;
        end else begin
            if (m_t == 0) begin
                m_div  = int'(clkdiv);
                m_r[0] = int'(clkphase0[DW-1:0]);
                m_f[0] = int'(clkphase0[2*DW-1:DW]);
                m_r[1] = int'(clkphase1[DW-1:0]);
                m_f[1] = int'(clkphase1[2*DW-1:DW]);
            end
            if (was_run) begin
                p = ((m_div == 0) ? 1 : m_div) + 1;
                k = (m_t - 3) % p;
                for (int i = 0; i < 2; i++) begin
                    if (k == m_r[i]) begin
                        m_rs[i] = !m_lvl[i]; m_lvl[i] = 1;
                    end else if (k == m_f[i]) begin
                        m_fs[i] = m_lvl[i]; m_lvl[i] = 0;
                    end
                end
            end
            m_t++;
        end
        if (!(m_active && m_t >= 4)) begin
            m_lvl[0] = 0; m_lvl[1] = 0;
        end
    endtask

    function automatic logic [6:0] model_vec();
        return {m_active && (m_t >= 3), m_lvl[0], m_lvl[1], m_rs[0], m_fs[0], m_rs[1], m_fs[1]};
    endfunction

    // Called at a negedge; drives inputs, advances one clock, checks against the model.
    task automatic step(input bit e, input bit c);
        en = e;
        clkchange = c;
        @(posedge clk);
        model_step(e, c);
        #1;
        check("model", 32'(dut_vec()), 32'(model_vec()));
        @(negedge clk);
    endtask

    task automatic set_cfg(input int d, input int r0, input int f0, input int r1, input int f1);
        clkdiv    = DW'(d);
        clkphase0 = {DW'(f0), DW'(r0)};
        clkphase1 = {DW'(f1), DW'(r1)};
    endtask

    typedef struct {
        bit         en;
        bit         chg;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int cnt_a;
        int cnt_b;
        int cnt_c;
        int cnt_d;
        bit prev;
        bit found;

        nreset = 1'b0; en = 1'b0; clkchange = 1'b0;
        set_cfg(7, 0, 4, 2, 6);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_state", 32'(dut_vec()), 32'd0);
        nreset = 1'b1;

        // Default waveform from the first en-high edge E to E+12.
        tbl[0]  = '{1, 0, 7'b0000000};
        tbl[1]  = '{1, 0, 7'b0000000};
        tbl[2]  = '{1, 0, 7'b0000000};
        tbl[3]  = '{1, 0, 7'b1000000};
        tbl[4]  = '{1, 0, 7'b1101000};
        tbl[5]  = '{1, 0, 7'b1100000};
        tbl[6]  = '{1, 0, 7'b1110010};
        tbl[7]  = '{1, 0, 7'b1110000};
        tbl[8]  = '{1, 0, 7'b1010100};
        tbl[9]  = '{1, 0, 7'b1010000};
        tbl[10] = '{1, 0, 7'b1000001};
        tbl[11] = '{1, 0, 7'b1000000};
        tbl[12] = '{1, 0, 7'b1101000};
        step(0, 0);
        step(0, 0);
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].en, tbl[i].chg);
            check($sformatf("default_row%0d", i), 32'(dut_vec()), 32'(tbl[i].exp));
        end
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 0);
            cnt_a += int'(rise0);
            cnt_b += int'(rise1);
        end
        check("default_rise0_per16", cnt_a, 2);
        check("default_rise1_per16", cnt_b, 2);

        // Divider 0 acts as 1: period 2, clkout0 toggles every cycle.
        step(0, 0);
        set_cfg(0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0);
        check("div0_stable", 32'(clkstable), 32'd1);
        cnt_a = 0; cnt_b = 0; prev = clkout0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0);
            check("div0_toggle", 32'(clkout0), 32'(!prev));
            prev = clkout0;
            cnt_a += int'(rise0);
            cnt_b += int'(fall0);
        end
        check("div0_rises", cnt_a, 4);
        check("div0_falls", cnt_b, 4);

        // clkchange in RUN; register values update after the write cycle.
        step(1, 1);
        check("chg_off_next", 32'(dut_vec()), 32'd0);
        set_cfg(3, 0, 2, 0, 2);
        cnt_a = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            cnt_a += int'(rise0 | fall0 | rise1 | fall1);
        end
        check("chg_no_strobe", cnt_a, 0);
        check("chg_stable_e3", 32'(clkstable), 32'd1);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0);
            cnt_a += int'(clkout0);
            cnt_b += int'(rise0);
        end
        check("chg_high_cycles", cnt_a, 4);
        check("chg_rises", cnt_b, 2);

        // rise==fall sticks high; fall beyond the divider never happens.
        step(0, 0);
        set_cfg(7, 1, 1, 3, 9);
        for (int i = 0; i < 4; i++) step(1, 0);
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
        for (int i = 0; i < 30; i++) begin
            step(1, 0);
            cnt_a += int'(rise0);
            cnt_b += int'(fall0);
            cnt_c += int'(rise1);
            cnt_d += int'(fall1);
        end
        check("stick_rise0", cnt_a, 1);
        check("stick_fall0", cnt_b, 0);
        check("stick_level0", 32'(clkout0), 32'd1);
        check("far_rise1", cnt_c, 1);
        check("far_fall1", cnt_d, 0);

        // en drop together with clkchange during a high phase.
        step(0, 0);
        set_cfg(7, 0, 4, 2, 6);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0);
            found = clkout0;
        end
        check("wait_clkout0_high", 32'(found), 32'd1);
        step(1, 0);
        step(0, 1);
        check("endrop_off", 32'(dut_vec()), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0);
        check("endrop_no_load", 32'(clkstable), 32'd0);

        // Asynchronous reset while running.
        for (int i = 0; i < 10; i++) step(1, 0);
        check("pre_reset_run", 32'(clkstable), 32'd1);
        #2;
        nreset = 1'b0;
        #1;
        check("async_reset", 32'(dut_vec()), 32'd0);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0);
        check("post_reset_off", 32'(clkstable), 32'd0);

        // Randomized traffic including ignored register writes outside LOAD.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 10) begin
                set_cfg($urandom_range(0, 9), $urandom_range(0, 11), $urandom_range(0, 11),
                        $urandom_range(0, 11), $urandom_range(0, 11));
            end
            step($urandom_range(0, 99) < 98, $urandom_range(0, 99) < 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
